i2c_reg_slave: RTL and testbench

//  I2C target with NUM_REGS byte-wide registers behind a register pointer; next generation of i2c_led_slave.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_sync.sv | 46 ++++
 rtl/i2c_reg_slave.sv | 185 ++++++++++++++++++
 tb/tb_i2c_reg_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_MACK,
    WAIT_STOP
  } state_t;

  localparam int   I2C_BYTE_BITS = 8;
  localparam logic ACK           = 1'b0;
  localparam logic NACK          = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into clk and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_meta;
  logic [SYNC_STAGES-1:0] sda_meta;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Chains reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta <= '1;
      sda_meta <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      scl_meta <= {scl_meta[SYNC_STAGES-2:0], scl};
      sda_meta <= {sda_meta[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_meta[SYNC_STAGES-1];
  assign sda_s = sda_meta[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target exposing NUM_REGS byte registers behind an auto-incrementing pointer.
module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h55,
  parameter int         NUM_REGS    = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  wr_strobe,
  output logic [3:0]            wr_index,
  output logic                  debug_addr_match,
  output logic [3:0]            debug_state
);

  import i2c_pkg::*;

  localparam int            PW         = $clog2(NUM_REGS);
  localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_REGS - 1);
  localparam logic [7:0]    NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [3:0]    BYTE_DONE  = 4'(I2C_BYTE_BITS);
  localparam logic [3:0]    MACK_SEEN  = BYTE_DONE + 4'd1;

  logic          sda_s, scl_rise, scl_fall, start_det, stop_det;
  state_t        state, state_nxt;
  logic [3:0]    bit_cnt, cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [PW-1:0] ptr, ptr_nxt, ptr_inc;
  logic          sda_drive, drive_nxt, match_nxt, reg_we;
  logic [7:0]    regs [NUM_REGS];
  logic [7:0]    rd_byte;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
  assign rd_byte = regs[ptr];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shift_nxt = shift;
    ptr_nxt   = ptr;
    drive_nxt = sda_drive;
    match_nxt = debug_addr_match;
    reg_we    = 1'b0;
    if (stop_det) begin
      state_nxt = IDLE;
      drive_nxt = 1'b0;
      match_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt = ADDR;
      cnt_nxt   = '0;
      drive_nxt = 1'b0;
      match_nxt = 1'b0;
    end else begin
      unique case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise && bit_cnt != BYTE_DONE) begin
            shift_nxt = {shift[6:0], sda_s};
            cnt_nxt   = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == BYTE_DONE) begin
            drive_nxt = 1'b1;
            if (state == ADDR) begin
              if (shift[7:1] == SLAVE_ADDR) begin
                state_nxt = ADDR_ACK;
                match_nxt = 1'b1;
              end else begin
                state_nxt = WAIT_STOP;
                drive_nxt = 1'b0;
              end
            end else if (state == PTR) begin
              if (shift < NUM_REGS_B) begin
                ptr_nxt   = shift[PW-1:0];
                state_nxt = PTR_ACK;
              end else begin
                state_nxt = WAIT_STOP;
                drive_nxt = 1'b0;
              end
            end else begin
              reg_we    = 1'b1;
              ptr_nxt   = ptr_inc;
              state_nxt = WDATA_ACK;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          // shift[0] still holds the R/W bit of the address byte.
          if (shift[0]) begin
            state_nxt = RDATA;
            shift_nxt = {rd_byte[6:0], 1'b0};
            drive_nxt = ~rd_byte[7];
            cnt_nxt   = 4'd1;
          end else begin
            state_nxt = PTR;
            drive_nxt = 1'b0;
            cnt_nxt   = '0;
          end
        end
        PTR_ACK, WDATA_ACK: if (scl_fall) begin
          state_nxt = WDATA;
          drive_nxt = 1'b0;
          cnt_nxt   = '0;
        end
        RDATA: if (scl_fall) begin
          if (bit_cnt == BYTE_DONE) begin
            state_nxt = RDATA_MACK;
            drive_nxt = 1'b0;
          end else begin
            drive_nxt = ~shift[7];
            shift_nxt = {shift[6:0], 1'b0};
            cnt_nxt   = bit_cnt + 4'd1;
          end
        end
        RDATA_MACK: begin
          // The pointer advances on the acknowledge clock; the next byte loads on its fall.
          if (scl_rise) begin
            ptr_nxt = ptr_inc;
            if (sda_s == NACK) state_nxt = WAIT_STOP;
            else               cnt_nxt   = MACK_SEEN;
          end else if (scl_fall && bit_cnt == MACK_SEEN) begin
            state_nxt = RDATA;
            shift_nxt = {rd_byte[6:0], 1'b0};
            drive_nxt = ~rd_byte[7];
            cnt_nxt   = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      shift            <= '0;
      ptr              <= '0;
      sda_drive        <= 1'b0;
      debug_addr_match <= 1'b0;
    end else begin
      state            <= state_nxt;
      bit_cnt          <= cnt_nxt;
      shift            <= shift_nxt;
      ptr              <= ptr_nxt;
      sda_drive        <= drive_nxt;
      debug_addr_match <= match_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the bank is a handful of flops whose reset value is visible on reg_q, so unlike a RAM it is reset.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
    end else begin
      wr_strobe <= reg_we;
      if (reg_we) begin
        regs[ptr] <= shift;
        wr_index  <= 4'(ptr);
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    assign reg_q[8*i +: 8] = regs[i];
  end

  assign sda         = sda_drive ? 1'b0 : 1'bz;
  assign debug_state = state;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: a bit-banged master, a write-vector table and hand sequences.
module tb_i2c_reg_slave;
  import i2c_pkg::*;

  localparam int Q = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  wire         sda_bus;
  logic [31:0] reg_q;
  logic        wr_strobe;
  logic [3:0]  wr_index;
  logic        debug_addr_match;
  logic [3:0]  debug_state;

  int          total = 0;
  int          bad = 0;
  int          strobe_cnt = 0;
  int          match_cycles = 0;
  logic [3:0]  last_idx = '0;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_reg_slave #(.SLAVE_ADDR(7'h55), .NUM_REGS(4), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .scl              (scl),
    .sda              (sda_bus),
    .reg_q            (reg_q),
    .wr_strobe        (wr_strobe),
    .wr_index         (wr_index),
    .debug_addr_match (debug_addr_match),
    .debug_state      (debug_state)
  );

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      last_idx   <= wr_index;
    end
    if (debug_addr_match) match_cycles <= match_cycles + 1;
  end

  typedef struct packed {
    logic [7:0]       addr;
    logic [7:0]       ptr;
    logic [1:0]       n;
    logic [2:0][7:0]  d;
    logic [4:0]       exp_ack;   // bit0 addr, bit1 ptr, bit2+k data byte k
    logic [31:0]      exp_q;
    logic [2:0]       exp_strobes;
    logic [3:0]       exp_idx;
    logic             exp_match;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic bit_in(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_start;
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic mack);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(mack);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic a;
    int   s0, m0;
    v  = vecs[i];
    s0 = strobe_cnt;
    m0 = match_cycles;
    i2c_start;
    send_byte(v.addr, a);
    check($sformatf("v%0d addr ack", i), 32'(a), 32'(v.exp_ack[0]));
    send_byte(v.ptr, a);
    check($sformatf("v%0d ptr ack", i), 32'(a), 32'(v.exp_ack[1]));
    for (int k = 0; k < int'(v.n); k++) begin
      send_byte(v.d[k], a);
      check($sformatf("v%0d data%0d ack", i, k), 32'(a), 32'(v.exp_ack[2+k]));
    end
    i2c_stop;
    check($sformatf("v%0d reg_q", i), reg_q, v.exp_q);
    check($sformatf("v%0d strobes", i), 32'(strobe_cnt - s0), 32'(v.exp_strobes));
    if (v.exp_strobes != 0) check($sformatf("v%0d wr_index", i), 32'(last_idx), 32'(v.exp_idx));
    check($sformatf("v%0d addr_match", i), 32'(match_cycles != m0), 32'(v.exp_match));
    check($sformatf("v%0d state idle", i), 32'(debug_state), 32'(IDLE));
  endtask

  initial begin
    logic       a;
    logic [7:0] rd0, rd1;
    int         s0;

    vecs[0] = '{addr: 8'hAA, ptr: 8'h00, n: 2'd1, d: {8'h00, 8'h00, 8'hFF}, exp_ack: 5'b00000,
                exp_q: 32'h0000_00FF, exp_strobes: 3'd1, exp_idx: 4'd0, exp_match: 1'b1};
    vecs[1] = '{addr: 8'hAA, ptr: 8'h01, n: 2'd3, d: {8'h3C, 8'h5A, 8'hA5}, exp_ack: 5'b00000,
                exp_q: 32'h3C5A_A5FF, exp_strobes: 3'd3, exp_idx: 4'd3, exp_match: 1'b1};
    vecs[2] = '{addr: 8'hAA, ptr: 8'h03, n: 2'd2, d: {8'h00, 8'h22, 8'h11}, exp_ack: 5'b00000,
                exp_q: 32'h115A_A522, exp_strobes: 3'd2, exp_idx: 4'd0, exp_match: 1'b1};
    vecs[3] = '{addr: 8'hAC, ptr: 8'h77, n: 2'd0, d: '0, exp_ack: 5'b00011,
                exp_q: 32'h115A_A522, exp_strobes: 3'd0, exp_idx: 4'd0, exp_match: 1'b0};
    vecs[4] = '{addr: 8'hAA, ptr: 8'h04, n: 2'd1, d: {8'h00, 8'h00, 8'h99}, exp_ack: 5'b00110,
                exp_q: 32'h115A_A522, exp_strobes: 3'd0, exp_idx: 4'd0, exp_match: 1'b1};

    #20;
    check("reset reg_q", reg_q, 32'h0);
    check("reset sda", 32'(sda_bus), 32'h1);
    check("reset wr_strobe", 32'(wr_strobe), 32'h0);
    check("reset wr_index", 32'(wr_index), 32'h0);
    check("reset addr_match", 32'(debug_addr_match), 32'h0);
    check("reset state", 32'(debug_state), 32'(IDLE));
    #20;
    rst = 1'b0;
    #100;

    for (int i = 0; i < 2; i++) run_vec(i);

    // Pointer write, repeated START, two-byte read.
    s0 = strobe_cnt;
    i2c_start;
    send_byte(8'hAA, a);  check("rd addr w ack", 32'(a), 32'(ACK));
    send_byte(8'h02, a);  check("rd ptr ack", 32'(a), 32'(ACK));
    i2c_start;
    send_byte(8'hAB, a);  check("rd addr r ack", 32'(a), 32'(ACK));
    recv_byte(rd0, ACK);
    recv_byte(rd1, NACK);
    i2c_stop;
    check("rd byte0", 32'(rd0), 32'h5A);
    check("rd byte1", 32'(rd1), 32'h3C);
    check("rd no strobes", 32'(strobe_cnt - s0), 32'h0);
    check("rd state idle", 32'(debug_state), 32'(IDLE));

    for (int i = 2; i < 5; i++) run_vec(i);

    // Reset while the slave is driving the address ACK.
    i2c_start;
    for (int i = 7; i >= 0; i--) bit_out(1'(8'hAA >> i));
    m_low = 1'b0;
    #Q;
    check("ack driven", 32'(sda_bus), 32'h0);
    rst = 1'b1;
    #10;
    check("ack released by rst", 32'(sda_bus), 32'h1);
    #20;
    rst = 1'b0;
    scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    i2c_stop;

    // Reset during bit 4 of a write data byte.
    i2c_start;
    send_byte(8'hAA, a);
    send_byte(8'h00, a);
    bit_out(1'b0); bit_out(1'b0); bit_out(1'b1);
    m_low = 1'b0; #Q; scl = 1'b1; #Q;
    rst = 1'b1;
    #10;
    check("mid rst sda", 32'(sda_bus), 32'h1);
    check("mid rst reg_q", reg_q, 32'h0);
    check("mid rst state", 32'(debug_state), 32'(IDLE));
    #20;
    rst = 1'b0;
    #Q; scl = 1'b0; #Q;
    i2c_stop;

    s0 = strobe_cnt;
    i2c_start;
    send_byte(8'hAA, a);  check("post rst addr ack", 32'(a), 32'(ACK));
    send_byte(8'h00, a);  check("post rst ptr ack", 32'(a), 32'(ACK));
    send_byte(8'h01, a);  check("post rst data ack", 32'(a), 32'(ACK));
    i2c_stop;
    check("post rst reg_q", reg_q, 32'h0000_0001);
    check("post rst strobes", 32'(strobe_cnt - s0), 32'h1);
    check("post rst wr_index", 32'(last_idx), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
